// File: rtl/simple_pipe_driver.sv
// simple_pipe_driver: buffers a short program, issues it to the pipeline, drains, then dumps the register file
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_inst/in_ready : program load port (accepted only while idle and not full)
//   start                     : begin a run, sampled only while idle
//   inst                      : registered instruction to the pipeline, 8'h00 when not issuing
//   dummy_read_rf/dummy_rf_data : pipeline register read port, driven during the dump
//   dump_valid/dump_idx/dump_data : captured register values, one per cycle after each dump read
//   busy, done, count, issued : run status, buffer occupancy and issue count
module simple_pipe_driver #(
  parameter int DEPTH = 8,
  parameter int DRAIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_inst,
  output logic                    in_ready,
  input  logic                    start,
  output logic [7:0]              inst,
  output logic [1:0]              dummy_read_rf,
  input  logic [7:0]              dummy_rf_data,
  output logic                    dump_valid,
  output logic [1:0]              dump_idx,
  output logic [7:0]              dump_data,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  issued
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DUMP, S_DONE} state_t;
  state_t state, nxt;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DW-1:0] dcnt;
  logic [1:0] dptr;
  logic empty, full, push, pop;
  assign empty = wr_ptr == rd_ptr;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push = in_valid & in_ready;
  assign pop = (state == S_ISSUE) && !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_ISSUE : S_IDLE;
      S_ISSUE: nxt = empty ? S_DRAIN : S_ISSUE;
      S_DRAIN: nxt = dcnt == '0 ? S_DUMP : S_DRAIN;
      S_DUMP:  nxt = dptr == 2'd3 ? S_DONE : S_DUMP;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = (state == S_IDLE) && !full;
    busy = state != S_IDLE;
    dummy_read_rf = state == S_DUMP ? dptr : 2'd0;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_inst;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      issued <= '0;
      inst <= 8'h00;
      dcnt <= '0;
      dptr <= 2'd0;
      dump_valid <= 1'b0;
      dump_idx <= 2'd0;
      dump_data <= 8'h00;
      done <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      issued <= (state == S_IDLE && start) ? '0 : issued + (AW+1)'(pop);
      inst <= pop ? mem[rd_ptr[AW-1:0]] : 8'h00;
      // loaded with DRAIN-1 so the drain state lasts exactly DRAIN cycles
      dcnt <= (state == S_ISSUE && empty) ? DW'(DRAIN - 1) :
              (state == S_DRAIN && dcnt != '0) ? dcnt - DW'(1) : dcnt;
      dptr <= state == S_DRAIN ? 2'd0 : state == S_DUMP ? dptr + 2'd1 : dptr;
      dump_valid <= state == S_DUMP;
      dump_idx <= state == S_DUMP ? dptr : dump_idx;
      dump_data <= state == S_DUMP ? dummy_rf_data : dump_data;
      done <= (state == S_DUMP) && (dptr == 2'd3);
    end
endmodule

// File: doc/simple_pipe_driver.md
# simple_pipe_driver

Program sequencer that sits at the opposite end of the simple 4-register pipeline's instruction/debug interface. It buffers a short program loaded over a valid/ready port and, on `start`, issues it one instruction per cycle onto the pipeline's 8-bit `inst` input. It then injects NOPs until the pipeline has drained, and dumps all four architectural registers through the pipeline's `dummy_read_rf`/`dummy_rf_data` read port. Used by test harnesses and the ILA refinement flow to drive and observe the pipeline as a whole.

## Interface
- `DEPTH`, 8: program buffer entries; power of 2, ≥2.
- `DRAIN`, 2: NOP cycles after the last issue before the register dump. Default is exact for the 3-stage pipeline.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `in_valid`  in  1  program load request.
- `in_inst`  in  8  instruction to load: {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
- `in_ready`  out  1  load accepted when `in_valid & in_ready`.
- `start`  in  1  begin issue; sampled only in IDLE.
- `inst`  out  8  registered instruction to the pipeline; 8'h00 (NOP) when not issuing.
- `dummy_read_rf`  out  2  register index driven to the pipeline read port.
- `dummy_rf_data`  in  8  combinational register value returned by the pipeline.
- `dump_valid`  out  1  `dump_data`/`dump_idx` are valid this cycle.
- `dump_idx`  out  2  register index of `dump_data`.
- `dump_data`  out  8  captured register value.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `count`  out  $clog2(DEPTH)+1  entries currently in the program buffer.
- `issued`  out  $clog2(DEPTH)+1  instructions issued since the last accepted `start`.

## Operation
- Program buffer: circular FIFO. Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Empty: pointers equal.
  - Full: indices equal and MSBs differ.
- `in_ready` = (state == IDLE) & ~full. A push is ignored whenever `in_ready` = 0.
- FSM states: IDLE, ISSUE, DRAIN, DUMP, DONE.
  - IDLE: `inst` = 0. On `start` → ISSUE and clear `issued`. A push and `start` in the same cycle are both taken, and the pushed entry is issued.
  - ISSUE, buffer non-empty: `inst` <= head, pop, `issued`++; stay in ISSUE.
  - ISSUE, buffer empty: `inst` <= 0, load the drain counter with DRAIN-1 → DRAIN.
  - DRAIN: `inst` = 0; decrement the counter each cycle. When the counter is 0 → DUMP with the dump pointer set to 0.
  - DUMP: `dummy_read_rf` = dump pointer. At the edge, `dump_data` <= `dummy_rf_data`, `dump_idx` <= pointer, `dump_valid` <= 1, pointer++. After pointer 3 → DONE.
  - DONE: `done` = 1 for exactly one cycle → IDLE. The buffer is empty here.
- `dummy_read_rf` = 0 outside DUMP. `dump_valid` is 0 except in the cycle after each DUMP cycle.
- `start` outside IDLE is ignored. There is no abort other than reset.
- Reset, including mid-run:
  - Immediately: state = IDLE, `inst` = 0, pointers = 0 (buffer empty), `issued` = 0.
  - Also 0: `dump_valid`, `dump_idx`, `dump_data`, `done`, drain counter and dump pointer.
  - Buffer storage is not reset.

## Timing
- With `start` sampled in cycle s and N entries buffered:
  - State is ISSUE in s+1.
  - Instruction k (0-based) appears on `inst` in cycle s+2+k.
  - `inst` = 0 from s+N+2.
  - DRAIN occupies cycles s+N+2 .. s+N+1+DRAIN.
  - DUMP occupies the next 4 cycles.
  - `dump_valid` is high in the 4 cycles after that; the last coincides with DONE/`done`.
  - `busy` is back to 0 in the following cycle.
- With DRAIN = 2, the first DUMP read occurs 3 cycles after the last real instruction is presented. This matches the pipeline's ID→EX→WB→RF write path.
- Issue throughput: one instruction per cycle, no bubbles.
- `inst`, `dump_*`, `done`, `issued` and `count` are registered. `in_ready`, `busy` and `dummy_read_rf` are decoded from registered state.

## Test plan
- Reset: pull `rst` low asynchronously mid-ISSUE, between clock edges → `inst` = 0x00, `busy` = 0, `count` = 0 before the next edge; after release, a reload and run behave normally.
- Normal run:
  - Stimulus: load 0x41, 0x86, 0xC7; pulse `start` in cycle s. The bench drives `dummy_rf_data` = 8'hA0 | `dummy_read_rf`.
  - Issue: `inst` = 0x41/0x86/0xC7 at s+2/s+3/s+4; 0x00 from s+5.
  - Dump: `dummy_read_rf` = 0..3 at s+7..s+10; `dump_valid` at s+8..s+11 with (idx, data) = (0,A0), (1,A1), (2,A2), (3,A3).
  - End: `done` at s+11; `issued` = 3.
- Full buffer: hold `in_valid` for 9 cycles with DEPTH = 8 → 8 accepted, `in_ready` = 0 at `count` = 8; the 9th value is never issued.
- Empty start: `start` with `count` = 0 → no non-zero `inst`; DUMP at s+4..s+7; `done` at s+8; `issued` = 0.
- Busy interlock: `in_valid` and `start` asserted during ISSUE/DRAIN/DUMP → `in_ready` = 0, `count` unchanged, no restart. A push together with `start` in IDLE is issued at s+2.
- Pointer wrap: run three successive 5-instruction programs with DEPTH = 8 → every program is issued in order with correct values across the pointer wrap.
